// File: rtl/conv1d_mac_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv1d_mac_if : kernel-load, sample-in and result-out signals.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface conv1d_mac_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] k_data;
  logic              k_ready;
  logic              clear;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              busy_load;

  modport slave (
    input  k_data, k_ready, clear, s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, busy_load
  );

  modport master (
    output k_data, k_ready, clear, s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, busy_load
  );
endinterface
`default_nettype wire

// File: rtl/conv1d_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv1d_mac : 3-tap streaming 1-D convolution, kernel loaded at start-up. |
// | Define CONV1D_MAC_SAT_EN to saturate the result instead of wrapping.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv1d_mac #(
  parameter int DATA_W = 32,
  parameter int TAPS   = 3
) (
  input  logic            clk,
  input  logic            reset,
  conv1d_mac_if.slave     bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]               idx;
  logic [1:0]               fill;
  logic signed [DATA_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] x0, x1, x2;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;

  logic                     loading;
  logic                     accept;
  logic                     s_ready_int;
  logic signed [PROD_W-1:0] p0, p1, p2;
  logic signed [SUM_W-1:0]  sum;
  logic [DATA_W-1:0]        result;
  logic                     unused_bits;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.k_ready) state_next = LOAD;
      LOAD:    if (bus.k_ready && idx == 2'd2) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign loading       = (state != RUN);
  assign s_ready_int   = (state == RUN) && (!out_valid || bus.m_ready) && !bus.clear;
  assign accept        = bus.s_valid && s_ready_int;
  assign bus.s_ready   = s_ready_int;
  assign bus.busy_load = loading;
  assign bus.m_data    = out_data;
  assign bus.m_valid   = out_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= 2'd0;
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else begin
      state <= state_next;
      if (loading && bus.k_ready) begin
        for (int i = 0; i < TAPS; i++) begin
          if (idx == i[1:0]) coef[i] <= $signed(bus.k_data);
        end
        idx <= idx + 2'd1;
      end
    end
  end

  // The incoming sample is x[n]; x0/x1 still hold x[n-1]/x[n-2] until the edge.
  assign p0  = coef[0] * $signed(bus.s_data);
  assign p1  = coef[1] * x0;
  assign p2  = coef[2] * x1;
  assign sum = SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2);

`ifdef CONV1D_MAC_SAT_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    result = sum[DATA_W-1:0];
    if (sum > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
  end

  assign unused_bits = ^x2;
`else
  assign result      = sum[DATA_W-1:0];
  assign unused_bits = ^{x2, sum[SUM_W-1:DATA_W]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      fill      <= 2'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (bus.clear) begin
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      fill      <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        x2 <= x1;
        x1 <= x0;
        x0 <= $signed(bus.s_data);
        if (fill != 2'd3) fill <= fill + 2'd1;
      end
      if (accept && fill >= 2'd2) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (bus.m_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv1d_mac : directed and random stimulus against a reference model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_conv1d_mac;

  localparam int DW = 32;
  localparam logic signed [65:0] SMAX = 66'sd2147483647;
  localparam logic signed [65:0] SMIN = -66'sd2147483648;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv1d_mac_if #(.DATA_W(DW)) bus();

  conv1d_mac #(.DATA_W(DW), .TAPS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  int          rmode  = 0;
  int          base;
  logic [31:0] coef_m [3];
  logic [31:0] hist [$];
  logic [31:0] exp_q [$];
  bit          prev_pend = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // y = sum of coef[k] * x[n-k], exact, then wrapped or clamped to 32 bits.
  function automatic logic [31:0] ref_out();
    logic signed [65:0] acc;
    acc = '0;
    for (int k = 0; k < 3; k++)
      acc += 66'($signed(coef_m[k])) * 66'($signed(hist[k]));
`ifdef CONV1D_MAC_SAT_EN
    if (acc > SMAX) return 32'h7FFF_FFFF;
    if (acc < SMIN) return 32'h8000_0000;
`endif
    return acc[31:0];
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check("hold_valid", 64'(bus.m_valid), 64'd1);
        check("hold_data", 64'(bus.m_data), 64'(prev_data));
      end
      if (bus.m_valid && !bus.m_ready) check("s_ready_stall", 64'(bus.s_ready), 64'd0);
      if (bus.m_valid && bus.m_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else check("m_data", 64'(bus.m_data), 64'(exp_q.pop_front()));
      end
      prev_pend = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.k_ready = 1'b0;
    bus.s_valid = 1'b0;
    bus.clear   = 1'b0;
    hist.delete();
    exp_q.delete();
    coef_m = '{32'd0, 32'd0, 32'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy_load", 64'(bus.busy_load), 64'd1);
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int gap);
    logic [31:0] k [3];
    k = '{a, b, c};
    for (int i = 0; i < 3; i++) begin
      bus.k_data  = k[i];
      bus.k_ready = 1'b1;
      if (i == 2) check("busy_load_load", 64'(bus.busy_load), 64'd1);
      tick(1);
      if (i == 0) begin
        repeat (gap) begin
          bus.k_ready = 1'b0;
          bus.k_data  = $urandom;
          tick(1);
        end
      end
    end
    bus.k_ready = 1'b0;
    bus.k_data  = $urandom;
    coef_m = '{a, b, c};
    check("busy_load_run", 64'(bus.busy_load), 64'd0);
    @(negedge clk);
    check("s_ready_run", 64'(bus.s_ready), 64'd1);
    tick(1);
  endtask

  task automatic send(input logic [31:0] v);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b1;
    bus.s_data  = v;
    bus.s_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_ready) begin
      n++;
      if (n > 300) begin
        check("s_ready_timeout", 64'd0, 64'd1);
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    if (ok) begin
      hist.push_front(v);
      if (hist.size() > 3) void'(hist.pop_back());
      if (hist.size() == 3) exp_q.push_back(ref_out());
    end
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom;
    if (ok && hist.size() == 3) check("latency_valid", 64'(bus.m_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rmode = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && n < 300) begin
      tick(1);
      n++;
    end
    check("drain_timeout", 64'(n < 300), 64'd1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_clear();
    drain();
    bus.clear   = 1'b1;
    bus.s_valid = 1'b1;
    @(negedge clk);
    check("clear_s_ready", 64'(bus.s_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.clear   = 1'b0;
    bus.s_valid = 1'b0;
    hist.delete();
    check("clear_m_valid", 64'(bus.m_valid), 64'd0);
  endtask

  initial begin
    bus.k_data  = '0;
    bus.k_ready = 1'b0;
    bus.clear   = 1'b0;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;

    do_reset();
    load3(32'd1, 32'd2, 32'd3, 0);
    base = n_out;
    send(32'd4);
    send(32'd5);
    send(32'd6);
    check("y_28", 64'(bus.m_data), 64'd28);
    send(32'd7);
    check("y_34", 64'(bus.m_data), 64'd34);
    drain();
    check("count_4567", 64'(n_out - base), 64'd2);

    // Downstream stall with a result pending.
    rmode = 2;
    tick(1);
    send(32'd8);
    bus.s_valid = 1'b1;
    tick(5);
    check("stall_m_valid", 64'(bus.m_valid), 64'd1);
    check("stall_m_data", 64'(bus.m_data), 64'd40);
    check("stall_s_ready", 64'(bus.s_ready), 64'd0);
    bus.s_valid = 1'b0;
    drain();

    // Reset mid-RUN, then mid-LOAD, then a gapped kernel load.
    send(32'd9);
    do_reset();
    bus.k_data  = 32'd50;
    bus.k_ready = 1'b1;
    tick(2);
    do_reset();
    load3(32'd1, 32'd2, 32'd3, 1);
    base = n_out;
    send(32'd10);
    send(32'd11);
    check("refill_no_out", 64'(bus.m_valid), 64'd0);
    send(32'd12);
    check("gap_y_64", 64'(bus.m_data), 64'd64);
    drain();
    check("count_gap", 64'(n_out - base), 64'd1);

    // Overflow boundary.
    do_reset();
    load3(32'd1, 32'd1, 32'd1, 0);
    repeat (3) send(32'h7FFF_FFFF);
`ifdef CONV1D_MAC_SAT_EN
    check("ovf_sat", 64'(bus.m_data), 64'h7FFF_FFFF);
`else
    check("ovf_wrap", 64'(bus.m_data), 64'h7FFF_FFFD);
`endif
    drain();

    // Clear after two samples: only new samples contribute.
    do_clear();
    send(32'd5);
    send(32'd6);
    do_clear();
    base = n_out;
    send(32'd1);
    send(32'd2);
    send(32'd3);
    check("clear_y_6", 64'(bus.m_data), 64'd6);
    drain();
    check("count_clear", 64'(n_out - base), 64'd1);

    // Random kernel, samples and back-pressure.
    do_reset();
    load3($urandom, $urandom, $urandom, $urandom_range(0, 3));
    rmode = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) send($urandom);
      else send(32'($urandom_range(0, 200)) - 32'd100);
      tick($urandom_range(0, 2));
      if (i == 30) begin
        do_clear();
        rmode = 1;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/conv1d_mac.md
CONV1D_MAC -- requirements
Module: conv1d_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the signed width of samples, coefficients and result.
REQ-002 SHALL have parameter TAPS, fixed at 3, the number of kernel coefficients; any other value is unsupported.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port k_data  input  DATA_W  kernel coefficient stream from the kernel FIFO stage.
REQ-006 SHALL have port k_ready  input  1  high when k_data carries a valid coefficient this cycle.
REQ-007 SHALL have port clear  input  1  synchronous flush of the sample window; kernel is retained.
REQ-008 SHALL have port s_data  input  DATA_W  signed input sample.
REQ-009 SHALL have port s_valid  input  1  s_data is valid.
REQ-010 SHALL have port s_ready  output  1  block accepts a sample this cycle.
REQ-011 SHALL have port m_data  output  DATA_W  signed convolution result.
REQ-012 SHALL have port m_valid  output  1  m_data is valid.
REQ-013 SHALL have port m_ready  input  1  downstream accepts m_data.
REQ-014 SHALL have port busy_load  output  1  high while in states IDLE or LOAD.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> RUN; IDLE -> LOAD on the first cycle k_ready=1; LOAD -> RUN once 3 coefficients are captured; RUN is terminal until reset.
REQ-016 SHALL capture k_data into coef[idx] on every cycle with k_ready=1 in IDLE or LOAD, idx counting 0,1,2 with no wrap; the IDLE-exit cycle captures coef[0].
REQ-017 SHALL hold idx and capture nothing on LOAD cycles with k_ready=0.
REQ-018 SHALL ignore k_data and k_ready in RUN.
REQ-019 SHALL drive s_ready = (state==RUN) && (!m_valid || m_ready).
REQ-020 SHALL treat a sample as accepted when s_valid && s_ready, and on acceptance shift x2<=x1, x1<=x0, x0<=s_data.
REQ-021 SHALL count accepted samples in a fill counter saturating at 3.
REQ-022 SHALL compute y = coef[0]*x[n] + coef[1]*x[n-1] + coef[2]*x[n-2], where x[n] is the sample just accepted, with full-precision signed products and sum (2*DATA_W+2 bits).
REQ-023 SHALL produce m_valid only for accepted samples for which the fill counter was already >= 2 before acceptance, i.e. from the third accepted sample onward.
REQ-024 SHALL register the result into m_data and set m_valid=1 on the edge after acceptance (latency 1 cycle).
REQ-025 SHALL hold m_data and m_valid stable while m_valid && !m_ready, and clear m_valid on m_ready unless a new result loads in the same cycle.
REQ-026 SHALL, by default, output the low DATA_W bits of the full sum (two's-complement wrap).
REQ-027 SHALL, when clear=1, zero x0..x2 and the fill counter and drop m_valid; clear takes priority over a simultaneous acceptance, and s_ready is forced 0 that cycle.

Reset
REQ-028 SHALL on reset=0 asynchronously set state=IDLE, idx=0, coef[0..2]=0, x0..x2=0, fill=0, m_data=0, m_valid=0, s_ready=0, busy_load=1.
REQ-029 SHALL, on reset asserted mid-LOAD or mid-RUN, discard all partial coefficients and window contents, and restart the kernel load after release.

Configuration
REQ-030 SHALL, when CONV1D_MAC_SAT_EN is defined, saturate the full sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1] instead of wrapping.
REQ-031 SHALL, without CONV1D_MAC_SAT_EN, use the wrap behaviour of REQ-026 and instantiate no saturation logic.

Verification
REQ-032 SHALL cover: k_ready=1 for 3 cycles with k_data 1,2,3 -> coef={1,2,3}, RUN entered, busy_load=0.
REQ-033 SHALL cover: with coef {1,2,3}, samples 4,5,6,7 and m_ready=1 -> m_valid only after 6 and 7, giving m_data 28 then 34.
REQ-034 SHALL cover: m_ready=0 for 5 cycles with a result pending -> s_ready=0 and m_data held until m_ready=1.
REQ-035 SHALL cover: k_ready gap after the first coefficient (1,-,2,3) -> coef={1,2,3}.
REQ-036 SHALL cover: coef={1,1,1}, samples 0x7FFFFFFF x3 -> wrap gives 0x7FFFFFFD; with CONV1D_MAC_SAT_EN gives 0x7FFFFFFF.
REQ-037 SHALL cover: clear issued after 2 samples, then 3 more samples -> exactly one output, computed from the new samples only.
